// File: rtl/dm_access_unit_if.sv
// Port bundles of dm_access_unit: pipeline request/response side and data-memory bus side.
interface dm_req_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic [1:0]        rsp_err;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );
  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

interface dm_mem_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  localparam int NB = DATA_W / 8;
  localparam int LB = $clog2(NB);

  logic                 mem_req;
  logic                 mem_we;
  logic [ADDR_W-LB-1:0] mem_addr;
  logic [NB-1:0]        mem_be;
  logic [DATA_W-1:0]    mem_wdata;
  logic [DATA_W-1:0]    mem_rdata;
  logic                 mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_rdata, mem_ack
  );
  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/dm_access_unit.sv
// Data-memory access unit: store lane formatting, load extraction/extension,
// alignment checking and a req/ack bus handshake with timeout.
module dm_access_unit #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic     clk,
  input  logic     reset,
  dm_req_if.slave  io_req,
  dm_mem_if.master io_mem
);
  localparam int NB    = DATA_W / 8;
  localparam int LB    = $clog2(NB);
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_t;

  state_t              r_state, w_next;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_we, r_uns;
  logic [1:0]          r_size, r_err;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata, r_rdata;
  logic                w_accept, w_illegal, w_timeout;

  function automatic logic [NB-1:0] f_lane_mask(input logic [1:0] size);
    logic [NB-1:0] m;
    for (int i = 0; i < NB; i++) m[i] = (i < (1 << size));
    return m;
  endfunction

  function automatic logic [DATA_W-1:0] f_store_data(input logic [DATA_W-1:0] d,
                                                     input logic [1:0] size,
                                                     input logic [LB-1:0] off);
    logic [NB-1:0]     m;
    logic [DATA_W-1:0] k;
    m = f_lane_mask(size);
    for (int i = 0; i < NB; i++) k[8*i +: 8] = m[i] ? d[8*i +: 8] : 8'h00;
    return k << {off, 3'b000};
  endfunction

  // The sign byte is the highest lane covered by the access size.
  function automatic logic [DATA_W-1:0] f_load_extend(input logic [DATA_W-1:0] d,
                                                      input logic [1:0] size,
                                                      input logic uns,
                                                      input logic [LB-1:0] off);
    logic [DATA_W-1:0] f, o;
    logic [NB-1:0]     m;
    logic [7:0]        fill;
    f    = d >> {off, 3'b000};
    m    = f_lane_mask(size);
    fill = 8'h00;
    for (int i = 0; i < NB; i++)
      if (i == (1 << size) - 1) fill = {8{!uns && f[8*i+7]}};
    for (int i = 0; i < NB; i++) o[8*i +: 8] = m[i] ? f[8*i +: 8] : fill;
    return o;
  endfunction

  assign w_accept  = io_req.req_valid && (r_state == S_IDLE) && !reset;
  assign w_illegal = (|(io_req.req_addr[2:0] & ((3'b001 << io_req.req_size) - 3'b001)))
                     || ((io_req.req_size == 2'd3) && (NB < 8));
  assign w_timeout = (TIMEOUT != 0) && (r_cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (io_req.req_valid) w_next = w_illegal ? S_RESP : S_BUS;
      S_BUS:   if (io_mem.mem_ack || w_timeout) w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Ack is checked before timeout so a late ack still completes cleanly.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt   <= '0;
      r_err   <= 2'd0;
      r_rdata <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: if (w_accept) begin
          r_cnt   <= '0;
          r_err   <= w_illegal ? 2'd1 : 2'd0;
          r_rdata <= '0;
        end
        S_BUS: if (io_mem.mem_ack) begin
          r_err   <= 2'd0;
          r_rdata <= r_we ? '0 : f_load_extend(io_mem.mem_rdata, r_size, r_uns, r_addr[LB-1:0]);
        end else begin
          r_cnt <= r_cnt + 1'b1;
          if (w_timeout) r_err <= 2'd2;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_we    <= io_req.req_we;
      r_size  <= io_req.req_size;
      r_uns   <= io_req.req_unsigned;
      r_addr  <= io_req.req_addr;
      r_wdata <= io_req.req_wdata;
    end
  end

  always_comb begin
    io_req.req_ready = (r_state == S_IDLE) && !reset;
    io_req.rsp_valid = (r_state == S_RESP);
    io_req.rsp_rdata = (r_state == S_RESP) ? r_rdata : '0;
    io_req.rsp_err   = (r_state == S_RESP) ? r_err : 2'd0;
    io_mem.mem_req   = (r_state == S_BUS);
    io_mem.mem_we    = 1'b0;
    io_mem.mem_addr  = '0;
    io_mem.mem_be    = '0;
    io_mem.mem_wdata = '0;
    if (r_state == S_BUS) begin
      io_mem.mem_we   = r_we;
      io_mem.mem_addr = r_addr[ADDR_W-1:LB];
      if (r_we) begin
        io_mem.mem_be    = f_lane_mask(r_size) << r_addr[LB-1:0];
        io_mem.mem_wdata = f_store_data(r_wdata, r_size, r_addr[LB-1:0]);
      end
    end
  end
endmodule

// File: tb/tb_dm_access_unit.sv
// Self-checking bench for dm_access_unit: a 32-bit and a 64-bit instance share one stimulus
// driver and are checked against an arithmetic reference model.
module tb_dm_access_unit;
  localparam int TO = 15;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dm_req_if #(.DATA_W(32), .ADDR_W(32)) rq32 ();
  dm_mem_if #(.DATA_W(32), .ADDR_W(32)) mm32 ();
  dm_req_if #(.DATA_W(64), .ADDR_W(32)) rq64 ();
  dm_mem_if #(.DATA_W(64), .ADDR_W(32)) mm64 ();

  dm_access_unit #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(TO)) u_dut32 (
    .clk(clk), .reset(reset), .io_req(rq32), .io_mem(mm32));
  dm_access_unit #(.DATA_W(64), .ADDR_W(32), .TIMEOUT(TO)) u_dut64 (
    .clk(clk), .reset(reset), .io_req(rq64), .io_mem(mm64));

  logic        t_sel, t_valid, t_we, t_uns, t_ack;
  logic [1:0]  t_size;
  logic [31:0] t_addr;
  logic [63:0] t_wdata, t_rdata;

  assign rq32.req_valid    = t_valid & ~t_sel;
  assign rq64.req_valid    = t_valid & t_sel;
  assign rq32.req_we       = t_we;
  assign rq64.req_we       = t_we;
  assign rq32.req_size     = t_size;
  assign rq64.req_size     = t_size;
  assign rq32.req_unsigned = t_uns;
  assign rq64.req_unsigned = t_uns;
  assign rq32.req_addr     = t_addr;
  assign rq64.req_addr     = t_addr;
  assign rq32.req_wdata    = t_wdata[31:0];
  assign rq64.req_wdata    = t_wdata;
  assign mm32.mem_rdata    = t_rdata[31:0];
  assign mm64.mem_rdata    = t_rdata;
  assign mm32.mem_ack      = t_ack & ~t_sel;
  assign mm64.mem_ack      = t_ack & t_sel;

  logic        o_ready, o_rsp_valid, o_mem_req, o_mem_we;
  logic [1:0]  o_rsp_err;
  logic [63:0] o_rsp_rdata, o_mem_wdata;
  logic [31:0] o_mem_addr;
  logic [7:0]  o_mem_be;
  assign o_ready     = t_sel ? rq64.req_ready : rq32.req_ready;
  assign o_rsp_valid = t_sel ? rq64.rsp_valid : rq32.rsp_valid;
  assign o_rsp_err   = t_sel ? rq64.rsp_err   : rq32.rsp_err;
  assign o_rsp_rdata = t_sel ? rq64.rsp_rdata : {32'b0, rq32.rsp_rdata};
  assign o_mem_req   = t_sel ? mm64.mem_req   : mm32.mem_req;
  assign o_mem_we    = t_sel ? mm64.mem_we    : mm32.mem_we;
  assign o_mem_addr  = t_sel ? {3'b0, mm64.mem_addr} : {2'b0, mm32.mem_addr};
  assign o_mem_be    = t_sel ? mm64.mem_be    : {4'b0, mm32.mem_be};
  assign o_mem_wdata = t_sel ? mm64.mem_wdata : {32'b0, mm32.mem_wdata};

  int n_cmp = 0;
  int n_fail = 0;
  logic [7:0]  last_be;
  logic [63:0] last_wdata, last_rdata;
  logic [31:0] last_addr;
  logic [1:0]  last_err;
  int          last_bus;

  // Reference: every value derived from byte counts and shifts on wide integers.
  function automatic void model(input bit sel, input logic we, input logic [1:0] size,
                                input logic uns, input logic [31:0] addr,
                                input logic [63:0] wd, input logic [63:0] rd,
                                output logic [1:0] err, output logic [7:0] be,
                                output logic [63:0] mwd, output logic [63:0] rdo,
                                output logic [31:0] waddr);
    int nb, bytes, off;
    logic [127:0] mask, fld;
    nb    = sel ? 8 : 4;
    bytes = 1 << size;
    off   = int'(addr % nb);
    err   = (((addr % bytes) != 0) || (bytes > nb)) ? 2'd1 : 2'd0;
    waddr = addr / nb;
    mask  = (128'd1 << (8 * bytes)) - 128'd1;
    be    = we ? 8'(((1 << bytes) - 1) << off) : 8'h00;
    mwd   = we ? 64'((128'(wd) & mask) << (8 * off)) : 64'h0;
    fld   = (128'(rd) >> (8 * off)) & mask;
    if (!uns && fld[8*bytes-1]) fld = fld | ~mask;
    rdo   = we ? 64'h0 : (sel ? fld[63:0] : {32'b0, fld[31:0]});
  endfunction

  task automatic run(input bit sel, input logic we, input logic [1:0] size, input logic uns,
                     input logic [31:0] addr, input logic [63:0] wd, input logic [63:0] rd,
                     input int ack_at, input bit spam, input string tag);
    logic [1:0]  e_err;
    logic [7:0]  e_be;
    logic [63:0] e_wd, e_rd, x_rd;
    logic [31:0] e_addr;
    logic [1:0]  x_err;
    int c;
    bit acked;
    model(sel, we, size, uns, addr, wd, rd, e_err, e_be, e_wd, e_rd, e_addr);
    t_sel = sel;
    n_cmp++;
    if (o_ready !== 1'b1) begin
      n_fail++; $display("FAIL %s ready_before: got %b want 1", tag, o_ready);
    end
    t_valid = 1'b1; t_we = we; t_size = size; t_uns = uns; t_addr = addr; t_wdata = wd;
    @(posedge clk); #1;
    t_valid = 1'b0; t_we = 1'($urandom); t_size = 2'($urandom); t_uns = 1'($urandom);
    t_addr = $urandom; t_wdata = {$urandom, $urandom};
    if (e_err == 2'd1) begin
      n_cmp++;
      if (o_mem_req !== 1'b0 || o_rsp_valid !== 1'b1 || o_rsp_err !== 2'd1 || o_rsp_rdata !== 64'h0) begin
        n_fail++;
        $display("FAIL %s illegal: req=%b vld=%b err=%0d rd=%h, want req=0 vld=1 err=1 rd=0",
                 tag, o_mem_req, o_rsp_valid, o_rsp_err, o_rsp_rdata);
      end
      last_err = o_rsp_err; last_rdata = o_rsp_rdata; last_bus = 0;
    end else begin
      c = 0; acked = 1'b0;
      while (1) begin
        n_cmp++;
        if (o_mem_req !== 1'b1 || o_rsp_valid !== 1'b0 || o_mem_we !== we || o_mem_addr !== e_addr
            || o_mem_be !== e_be || o_mem_wdata !== e_wd) begin
          n_fail++;
          $display("FAIL %s bus[%0d]: req=%b vld=%b we=%b addr=%h be=%h wd=%h, want req=1 vld=0 we=%b addr=%h be=%h wd=%h",
                   tag, c, o_mem_req, o_rsp_valid, o_mem_we, o_mem_addr, o_mem_be, o_mem_wdata,
                   we, e_addr, e_be, e_wd);
        end
        if (c == 0) begin
          last_be = o_mem_be; last_wdata = o_mem_wdata; last_addr = o_mem_addr;
        end
        t_ack   = (c == ack_at);
        t_rdata = t_ack ? rd : {$urandom, $urandom};
        if (spam) t_valid = 1'b1;
        acked = t_ack;
        @(posedge clk); #1;
        t_ack = 1'b0; t_valid = 1'b0;
        c++;
        if (acked || c == TO || c >= 40) break;
      end
      last_bus = c;
      x_err = acked ? 2'd0 : 2'd2;
      x_rd  = acked ? e_rd : 64'h0;
      n_cmp++;
      if (o_rsp_valid !== 1'b1 || o_rsp_err !== x_err || o_rsp_rdata !== x_rd
          || o_mem_req !== 1'b0 || o_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL %s resp: vld=%b err=%0d rd=%h req=%b rdy=%b, want vld=1 err=%0d rd=%h req=0 rdy=0",
                 tag, o_rsp_valid, o_rsp_err, o_rsp_rdata, o_mem_req, o_ready, x_err, x_rd);
      end
      last_err = o_rsp_err; last_rdata = o_rsp_rdata;
    end
    @(posedge clk); #1;
    n_cmp++;
    if (o_rsp_valid !== 1'b0 || o_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s after: vld=%b rdy=%b, want vld=0 rdy=1", tag, o_rsp_valid, o_ready);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; t_valid = 1'b0; t_ack = 1'b0; t_sel = 1'b0;
    t_we = 1'b0; t_size = 2'd0; t_uns = 1'b0; t_addr = '0; t_wdata = '0; t_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (rq32.req_ready !== 1'b0 || rq64.req_ready !== 1'b0 || mm32.mem_req !== 1'b0
        || mm64.mem_req !== 1'b0 || rq32.rsp_valid !== 1'b0 || rq64.rsp_valid !== 1'b0
        || rq32.rsp_err !== 2'd0 || mm32.mem_be !== 4'h0 || mm64.mem_wdata !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_state: rdy=%b/%b req=%b/%b vld=%b/%b, want all 0",
               rq32.req_ready, rq64.req_ready, mm32.mem_req, mm64.mem_req,
               rq32.rsp_valid, rq64.rsp_valid);
    end
    reset = 1'b0; #1;
    n_cmp++;
    if (rq32.req_ready !== 1'b1 || rq64.req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release: rdy=%b/%b want 1/1", rq32.req_ready, rq64.req_ready);
    end
  endtask

  task automatic test_directed();
    run(0, 1, 2'd0, 0, 32'h1003, 64'hA5, 64'h0, 0, 0, "sb");
    n_cmp++;
    if (last_be !== 8'h08 || last_wdata !== 64'hA500_0000 || last_addr !== 32'h400 || last_err !== 2'd0) begin
      n_fail++;
      $display("FAIL sb_const: be=%h wd=%h addr=%h err=%0d, want 08 a5000000 400 0",
               last_be, last_wdata, last_addr, last_err);
    end
    run(0, 0, 2'd1, 0, 32'h2002, 64'h0, 64'h8001_1234, 1, 0, "lh");
    n_cmp++;
    if (last_rdata !== 64'hFFFF_8001) begin
      n_fail++; $display("FAIL lh_const: got %h want ffff8001", last_rdata);
    end
    run(0, 0, 2'd1, 1, 32'h2002, 64'h0, 64'h8001_1234, 0, 0, "lhu");
    n_cmp++;
    if (last_rdata !== 64'h0000_8001) begin
      n_fail++; $display("FAIL lhu_const: got %h want 00008001", last_rdata);
    end
    run(0, 0, 2'd2, 0, 32'h0006, 64'h0, 64'h0, 0, 0, "lw_mis");
    n_cmp++;
    if (last_err !== 2'd1) begin
      n_fail++; $display("FAIL lw_mis_const: err=%0d want 1", last_err);
    end
    run(0, 1, 2'd2, 0, 32'h0040, 64'h1234_5678, 64'h0, -1, 0, "sw_timeout");
    n_cmp++;
    if (last_err !== 2'd2 || last_bus != TO) begin
      n_fail++; $display("FAIL timeout_const: err=%0d bus=%0d want 2 %0d", last_err, last_bus, TO);
    end
    run(0, 1, 2'd2, 0, 32'h0040, 64'h1234_5678, 64'h0, TO - 1, 0, "sw_late_ack");
    n_cmp++;
    if (last_err !== 2'd0) begin
      n_fail++; $display("FAIL late_ack_const: err=%0d want 0", last_err);
    end
    run(1, 1, 2'd3, 0, 32'h0010, 64'h0123_4567_89AB_CDEF, 64'h0, 0, 0, "sd64");
    n_cmp++;
    if (last_be !== 8'hFF) begin
      n_fail++; $display("FAIL sd64_be: got %h want ff", last_be);
    end
    run(1, 0, 2'd2, 0, 32'h0014, 64'h0, 64'h8000_0000_0000_0000, 2, 0, "lw64");
    n_cmp++;
    if (last_rdata !== 64'hFFFF_FFFF_8000_0000) begin
      n_fail++; $display("FAIL lw64_const: got %h want ffffffff80000000", last_rdata);
    end
    run(0, 0, 2'd3, 0, 32'h0008, 64'h0, 64'h0, 0, 0, "ld_on32");
  endtask

  task automatic test_random();
    logic [1:0]  sz;
    logic [31:0] a;
    int ack_at;
    for (int i = 0; i < 120; i++) begin
      sz = 2'($urandom);
      a  = $urandom;
      if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 32'd1);
      case ($urandom_range(0, 9))
        0:       ack_at = -1;
        1:       ack_at = TO - 1;
        default: ack_at = $urandom_range(0, 4);
      endcase
      run(1'($urandom), 1'($urandom), sz, 1'($urandom), a, {$urandom, $urandom},
          {$urandom, $urandom}, ack_at, 1'($urandom), "rand");
    end
  endtask

  task automatic test_ignore_ack();
    t_sel = 1'b0; t_valid = 1'b0; t_ack = 1'b1; t_rdata = {$urandom, $urandom};
    repeat (2) @(posedge clk);
    #1;
    t_ack = 1'b0;
    n_cmp++;
    if (o_rsp_valid !== 1'b0 || o_mem_req !== 1'b0 || o_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL idle_ack: vld=%b req=%b rdy=%b, want 0 0 1", o_rsp_valid, o_mem_req, o_ready);
    end
  endtask

  task automatic test_reset_mid();
    t_sel = 1'b0; t_valid = 1'b1; t_we = 1'b1; t_size = 2'd2; t_addr = 32'h100; t_wdata = 64'hDEAD_BEEF;
    @(posedge clk); #1;
    t_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (o_mem_req !== 1'b1) begin
      n_fail++; $display("FAIL mid_busy: req=%b want 1", o_mem_req);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (o_mem_req !== 1'b0 || o_rsp_valid !== 1'b0 || o_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: req=%b vld=%b rdy=%b, want 0 0 0", o_mem_req, o_rsp_valid, o_ready);
    end
    reset = 1'b0; #1;
    n_cmp++;
    if (o_ready !== 1'b1) begin
      n_fail++; $display("FAIL mid_release: rdy=%b want 1", o_ready);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (o_rsp_valid !== 1'b0 || o_mem_req !== 1'b0) begin
      n_fail++; $display("FAIL mid_after: vld=%b req=%b want 0 0", o_rsp_valid, o_mem_req);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_ignore_ack();
    test_reset_mid();
    test_random();
    run(1, 0, 2'd0, 0, 32'h0007, 64'h0, 64'h8000_0000_0000_0000, 0, 1, "lb64_top");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
